// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: default operand width and FSM state encoding.
package serial_adder_pkg;

    localparam int SA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle between the upstream source (master) and the adder (slave).
// Optional signed-overflow flag is present only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Combinational single-bit full-adder cell (sum and majority carry) used by the serial adder.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two operands, adds one bit per clock LSB-first, and holds the result.
// Build option SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] s_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             s_bit_s;
    logic             co_bit_s;
    logic [WIDTH-1:0] s_next_s;

    serial_fa_bit u_fa (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .ci (carry_r),
        .s  (s_bit_s),
        .co (co_bit_s)
    );

    assign s_next_s = {s_bit_s, s_sh_r[WIDTH-1:1]};

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;

    // Signed overflow: carry into the MSB (the live carry on the last bit) differs from carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state_r == ST_SHIFT && cnt_r == LAST_BIT) begin
            ovf_r <= carry_r ^ co_bit_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign bus.ovf = ovf_r;
`endif

    // Control FSM with operand/sum shift registers, bit counter and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            s_sh_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.b;
                        carry_r <= bus.cin;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    s_sh_r  <= s_next_s;
                    carry_r <= co_bit_s;
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_BIT) begin
                        sum_r   <= s_next_s;
                        cout_r  <= co_bit_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, handshake corner cases, random ops.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic ovf_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    logic [W-1:0] r_sum;
    logic         r_cout;
    logic         r_ovf;
    int           r_lat;
    int           r_busy;
    logic         r_done_after;
    logic         r_busy_after;

    // One addition: start for one cycle, scramble the inputs after acceptance, wait for done.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = c;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        r_lat = -1; r_busy = 0;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) @(negedge clk);
            if (bus.busy) r_busy++;
            if (bus.done) begin
                r_lat = n;
                break;
            end
        end
        r_sum = bus.sum; r_cout = bus.cout;
`ifdef SERIAL_ADD_OVF_EN
        r_ovf = bus.ovf;
`else
        r_ovf = 1'b0;
`endif
        @(negedge clk);
        r_done_after = bus.done;
        r_busy_after = bus.busy;
    endtask

    int pulses;
    int last_pulse;
    int bad_gap;
    int bad_sum;

    initial begin
        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[5] = '{8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1, 1'b0};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_sum",  32'(bus.sum),  32'd0);
        chk("reset_cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin);
            chk($sformatf("vec%0d_latency", i), 32'(r_lat), 32'(W));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(r_busy), 32'(W + 1));
            chk($sformatf("vec%0d_sum", i), 32'(r_sum), 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_cout", i), 32'(r_cout), 32'(vecs[i].exp_cout));
`ifdef SERIAL_ADD_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 32'(r_ovf), 32'(vecs[i].exp_ovf));
`endif
            chk($sformatf("vec%0d_done_one_cycle", i), 32'(r_done_after), 32'd0);
            chk($sformatf("vec%0d_idle_after", i), 32'(r_busy_after), 32'd0);
            chk($sformatf("vec%0d_sum_held", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
        end

        // Start pulsed during the 3rd SHIFT cycle must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h35; bus.b = 8'h4A; bus.cin = 1'b0;
        pulses = 0; r_sum = '0;
        for (int n = -1; n < 24; n++) begin
            @(negedge clk);
            bus.start = (n == 1);
            if (n == 1) begin bus.a = 8'h01; bus.b = 8'h01; end
            if (bus.done) begin pulses++; r_sum = bus.sum; end
        end
        chk("ignored_start_pulses", 32'(pulses), 32'd1);
        chk("ignored_start_sum", 32'(r_sum), 32'h7F);
        chk("ignored_start_idle", 32'(bus.busy), 32'd0);

        // Reset in the 4th SHIFT cycle clears everything, with no done afterwards.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h35; bus.b = 8'h4A; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_sum",  32'(bus.sum),  32'd0);
        chk("midreset_cout", 32'(bus.cout), 32'd0);
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus.done || bus.busy) pulses++;
            @(negedge clk);
        end
        chk("midreset_no_done", 32'(pulses), 32'd0);
        do_add(8'h10, 8'h20, 1'b0);
        chk("after_reset_sum", 32'(r_sum), 32'h30);
        chk("after_reset_latency", 32'(r_lat), 32'(W));

        // Start held for 30 cycles: relaunch every WIDTH+2 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
        pulses = 0; last_pulse = -1; bad_gap = 0; bad_sum = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.done) begin
                if (pulses == 0 && n != W) bad_gap++;
                if (pulses > 0 && (n - last_pulse) != W + 2) bad_gap++;
                pulses++;
                last_pulse = n;
            end
            if (pulses > 0 && bus.sum !== 8'h03) bad_sum++;
        end
        bus.start = 1'b0;
        chk("held_start_pulses", 32'(pulses), 32'd3);
        chk("held_start_spacing", 32'(bad_gap), 32'd0);
        chk("held_start_sum_stable", 32'(bad_sum), 32'd0);
        for (int n = 0; n < 20 && bus.busy; n++) @(negedge clk);
        chk("held_start_drain", 32'(bus.busy), 32'd0);

        // Random operations against plain-arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            logic [W:0]   full;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            do_add(ra, rb, rc);
            chk($sformatf("rand%0d_result", i), {22'd0, r_lat == W, r_cout, r_sum},
                {22'd0, 1'b1, full[W], full[W-1:0]});
`ifdef SERIAL_ADD_OVF_EN
            chk($sformatf("rand%0d_ovf", i), 32'(r_ovf), 32'(ovf_of(ra, rb, full[W-1:0])));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
